conv_out_streamer: RTL and testbench

//  Downstream stage of conv2d: captures the flat output tensor on a start pulse, applies an

---
 rtl/conv_pkg.sv | 23 ++
 rtl/activation_unit.sv | 26 ++
 rtl/conv_out_streamer.sv | 143 ++++++++++++++
 tb/tb_conv_out_streamer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d layer family: activation selectors, streamer FSM
// encoding and the default element width.
package conv_pkg;

  localparam int CONV_DATA_WIDTH = 32;

  localparam int ACT_NONE  = 0;
  localparam int ACT_RELU  = 1;
  localparam int ACT_LEAKY = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  // Width of an index counter for n values; never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/activation_unit.sv
// Combinational element activation: pass-through, ReLU, or LeakyReLU via arithmetic shift.
import conv_pkg::*;

module activation_unit #(
  parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
  parameter int ACT_MODE    = ACT_RELU,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] y
);

  // NOTE: y gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    y = x;
    if (x[DATA_WIDTH-1]) begin
      case (ACT_MODE)
        ACT_RELU:  y = '0;
        // Arithmetic shift rounds toward -inf, so small negatives settle at -1, not 0.
        ACT_LEAKY: y = x >>> LEAKY_SHIFT;
        default:   y = x;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_streamer.sv
// Captures the flat conv2d output tensor on start and streams activated, tagged elements
// over a valid/ready interface, one element per accepted handshake.
import conv_pkg::*;

module conv_out_streamer #(
  parameter int DATA_WIDTH   = CONV_DATA_WIDTH,
  parameter int BATCH_SIZE   = 1,
  parameter int OUT_CHANNELS = 32,
  parameter int OUT_HEIGHT   = 7,
  parameter int OUT_WIDTH    = 7,
  parameter int ACT_MODE     = ACT_RELU,
  parameter int LEAKY_SHIFT  = 3,
  localparam int NUM_ELEMS   = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH,
  localparam int CHAN_W      = tag_width(OUT_CHANNELS),
  localparam int ROW_W       = tag_width(OUT_HEIGHT),
  localparam int COL_W       = tag_width(OUT_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0] tensor_flat,
  output logic                            busy,
  output logic                            done,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [CHAN_W-1:0]               m_chan,
  output logic [ROW_W-1:0]                m_row,
  output logic [COL_W-1:0]                m_col,
  output logic                            m_last_row,
  output logic                            m_last
);

  localparam int IDX_W = tag_width(NUM_ELEMS);

  stream_state_t state, state_nxt;

  logic [NUM_ELEMS*DATA_WIDTH-1:0] capture;
  logic [IDX_W-1:0]                nxt_idx;
  logic [CHAN_W-1:0]               nxt_chan;
  logic [ROW_W-1:0]                nxt_row;
  logic [COL_W-1:0]                nxt_col;

  logic                  start_ok;
  logic                  accept;
  logic                  load_elem;
  logic                  nxt_col_end;
  logic                  nxt_row_end;
  logic                  nxt_chan_end;
  logic                  nxt_is_last;
  logic [DATA_WIDTH-1:0] sel_elem;
  logic [DATA_WIDTH-1:0] act_elem;

  assign start_ok     = start && (state == IDLE);
  assign accept       = m_valid && m_ready;
  assign load_elem    = (state == LOAD) || ((state == STREAM) && accept && !m_last);
  assign nxt_col_end  = (nxt_col  == COL_W'(OUT_WIDTH - 1));
  assign nxt_row_end  = (nxt_row  == ROW_W'(OUT_HEIGHT - 1));
  assign nxt_chan_end = (nxt_chan == CHAN_W'(OUT_CHANNELS - 1));
  assign nxt_is_last  = (nxt_idx  == IDX_W'(NUM_ELEMS - 1));
  assign sel_elem     = capture[nxt_idx * DATA_WIDTH +: DATA_WIDTH];

  assign busy = (state == LOAD) || (state == STREAM);
  assign done = (state == DONE);

  activation_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACT_MODE   (ACT_MODE),
    .LEAKY_SHIFT(LEAKY_SHIFT)
  ) u_act (
    .x(sel_elem),
    .y(act_elem)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = STREAM;
      STREAM:  if (accept && m_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the capture register is wide storage with no meaningful reset value, so it is
  // deliberately left out of reset; only the control path and outputs are cleared.
  always_ff @(posedge clk) begin
    if (start_ok) capture <= tensor_flat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_chan     <= '0;
      m_row      <= '0;
      m_col      <= '0;
      m_last_row <= 1'b0;
      m_last     <= 1'b0;
      nxt_idx    <= '0;
      nxt_chan   <= '0;
      nxt_row    <= '0;
      nxt_col    <= '0;
    end else if (start_ok) begin
      nxt_idx  <= '0;
      nxt_chan <= '0;
      nxt_row  <= '0;
      nxt_col  <= '0;
    end else if (load_elem) begin
      m_valid    <= 1'b1;
      m_data     <= act_elem;
      m_chan     <= nxt_chan;
      m_row      <= nxt_row;
      m_col      <= nxt_col;
      m_last_row <= nxt_col_end;
      m_last     <= nxt_is_last;
      // The flat index and the chan/row/col tags advance together; the batch boundary
      // is simply the channel counter wrapping.
      nxt_idx    <= nxt_idx + IDX_W'(1);
      if (nxt_col_end) begin
        nxt_col <= '0;
        if (nxt_row_end) begin
          nxt_row  <= '0;
          nxt_chan <= nxt_chan_end ? '0 : nxt_chan + CHAN_W'(1);
        end else begin
          nxt_row <= nxt_row + ROW_W'(1);
        end
      end else begin
        nxt_col <= nxt_col + COL_W'(1);
      end
    end else if ((state == STREAM) && accept) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_out_streamer.sv
// Self-checking bench for conv_out_streamer on a 2x2x2 tensor, ReLU and LeakyReLU instances.
module tb_conv_out_streamer;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int NH = 2;
  localparam int NW = 2;
  localparam int NE = NC * NH * NW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NE*DW-1:0] tensor_flat;
  logic            m_ready;

  logic            busy, done, m_valid, m_last_row, m_last;
  logic [DW-1:0]   m_data;
  logic            m_chan, m_row, m_col;

  logic            busy_l, done_l, m_valid_l, m_last_row_l, m_last_l;
  logic [DW-1:0]   m_data_l;
  logic            m_chan_l, m_row_l, m_col_l;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] cap [NE];

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] relu;
    logic [DW-1:0] leaky;
  } vec_t;

  vec_t vecs [NE];

  always #5 clk = ~clk;

  conv_out_streamer #(
    .DATA_WIDTH(DW), .BATCH_SIZE(1), .OUT_CHANNELS(NC), .OUT_HEIGHT(NH),
    .OUT_WIDTH(NW), .ACT_MODE(1), .LEAKY_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tensor_flat(tensor_flat),
    .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_chan(m_chan), .m_row(m_row), .m_col(m_col),
    .m_last_row(m_last_row), .m_last(m_last)
  );

  conv_out_streamer #(
    .DATA_WIDTH(DW), .BATCH_SIZE(1), .OUT_CHANNELS(NC), .OUT_HEIGHT(NH),
    .OUT_WIDTH(NW), .ACT_MODE(2), .LEAKY_SHIFT(3)
  ) dut_leaky (
    .clk(clk), .rst(rst), .start(start), .tensor_flat(tensor_flat),
    .busy(busy_l), .done(done_l), .m_valid(m_valid_l), .m_ready(m_ready),
    .m_data(m_data_l), .m_chan(m_chan_l), .m_row(m_row_l), .m_col(m_col_l),
    .m_last_row(m_last_row_l), .m_last(m_last_l)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference activation from the arithmetic definition: floor(x / 8) for leaky negatives.
  function automatic logic [DW-1:0] ref_act(input int mode, input logic [DW-1:0] x);
    longint v;
    v = longint'($signed(x));
    if (v >= 0 || mode == 0) return x;
    if (mode == 1) return '0;
    return DW'((v - 7) / 8);
  endfunction

  task automatic start_stream();
    @(negedge clk);
    for (int i = 0; i < NE; i++) tensor_flat[i*DW +: DW] = cap[i];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_in_load", m_valid, 0);
  endtask

  // Drives m_ready per mode (0 always, 1 toggle, 2 random), scores every acceptance against
  // the model built from cap, optionally pulses start once k acceptances have occurred.
  task automatic collect(input int ready_mode, input int inject_at);
    int k = 0;
    int cyc = 0;
    int post = 0;
    bit seen_done = 0;
    bit injected = 0;
    bit prev_stall = 0;
    logic [DW-1:0] h_data;
    logic [4:0]    h_tags;
    while (post < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2) == 1;
        default: m_ready = ($urandom_range(0, 2) != 0);
      endcase
      start = 1'b0;
      if (inject_at >= 0 && k == inject_at && !injected) begin
        start = 1'b1;
        injected = 1;
      end
      if (k == NE && !seen_done) begin
        check("done_pulse", done, 1);
        check("busy_falls_with_done", busy, 0);
        check("valid_drops_after_last", m_valid, 0);
        seen_done = 1;
      end else if (seen_done) begin
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("no_restart", m_valid, 0);
        post++;
      end else begin
        check("done_early", done, 0);
        check("busy_while_stream", busy, 1);
        check("valid_no_gap", m_valid, 1);
        if (prev_stall) begin
          check("hold_data", m_data, h_data);
          check("hold_tags", {m_chan, m_row, m_col, m_last_row, m_last}, h_tags);
        end
        if (m_valid && m_ready) begin
          check("data", m_data, ref_act(1, cap[k]));
          check("data_leaky", m_data_l, ref_act(2, cap[k]));
          check("chan", m_chan, (k / (NH*NW)) % NC);
          check("row", m_row, (k / NW) % NH);
          check("col", m_col, k % NW);
          check("last_row", m_last_row, (k % NW) == NW - 1);
          check("last", m_last, k == NE - 1);
          k++;
        end
        prev_stall = m_valid && !m_ready;
        h_data = m_data;
        h_tags = {m_chan, m_row, m_col, m_last_row, m_last};
      end
    end
    start = 1'b0;
    check("accept_count", k, NE);
    check("stream_completed", post, 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; tensor_flat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_tags", {m_chan, m_row, m_col, m_last_row, m_last}, 0);
    check("rst_leaky_valid", m_valid_l, 0);
    rst = 1'b0;

    // Activation table through both instances with continuous m_ready.
    vecs[0] = '{32'h00000001, 32'h00000001, 32'h00000001};
    vecs[1] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
    vecs[2] = '{32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFFE};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[5] = '{32'h80000000, 32'h00000000, 32'hF0000000};
    vecs[6] = '{32'h00000000, 32'h00000000, 32'h00000000};
    vecs[7] = '{32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFFE};
    for (int i = 0; i < NE; i++) cap[i] = vecs[i].x;
    start_stream();
    m_ready = 1'b1;
    for (int i = 0; i < NE; i++) begin
      @(negedge clk);
      check("tbl_valid", m_valid, 1);
      check("tbl_relu", m_data, vecs[i].relu);
      check("tbl_leaky", m_data_l, vecs[i].leaky);
    end
    @(negedge clk);
    check("tbl_done", done, 1);
    check("tbl_leaky_done", done_l, 1);
    repeat (2) @(negedge clk);

    // Reference sequence 1,-2,3,-4,5,6,-7,8: continuous ready, then toggling ready.
    cap[0] = 1;  cap[1] = -2; cap[2] = 3;  cap[3] = -4;
    cap[4] = 5;  cap[5] = 6;  cap[6] = -7; cap[7] = 8;
    start_stream();
    collect(0, -1);
    start_stream();
    collect(1, -1);

    // Start pulse while element 3 is on the bus is ignored.
    start_stream();
    collect(0, 3);

    // Reset while element 4 is presented, then a clean restart from (0,0,0).
    start_stream();
    m_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_data", m_data, ref_act(1, cap[4]));
    check("pre_rst_col", m_col, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < NE; i++) cap[i] = 100 + i;
    start_stream();
    collect(2, -1);

    // Tensor changes right after capture; streamed values must be the captured ones.
    for (int i = 0; i < NE; i++) cap[i] = -(i * 9) + 20;
    start_stream();
    for (int i = 0; i < NE; i++) tensor_flat[i*DW +: DW] = $urandom;
    collect(0, -1);

    // Randomized tensors and backpressure against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NE; i++)
        cap[i] = ($urandom_range(0, 1) == 1) ? $urandom : DW'(-int'($urandom_range(0, 40)));
      start_stream();
      collect(2, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
